// File: rtl/bias_buffer_pp.sv
// Double-buffered per-channel bias store: a shadow bank loads from the
// stream while the datapath reads the active bank; a handshake swaps them.
module bias_buffer_pp #(
   parameter int STREAM_W = 64,
   parameter int BIAS_W   = 32,
   parameter int CH_NUM   = 8,
   parameter int DEPTH    = 128,
   parameter int ADDR_W   = 7
) (
   input  logic                     sclk,
   input  logic                     s_rst_n,
   input  logic [STREAM_W-1:0]      stream_rx_data,
   input  logic                     stream_bias_vld,
   input  logic                     write_finish,
   input  logic                     bank_swap,
   input  logic                     bias_rd_en,
   input  logic [ADDR_W-1:0]        bias_rd_addr,
   output logic [CH_NUM*BIAS_W-1:0] bias_data,
   output logic                     bias_data_vld,
   output logic                     load_done,
   output logic                     active_bank,
   output logic                     wr_overflow
);

   localparam int LANES = STREAM_W / BIAS_W;
   localparam int NSEL  = CH_NUM / LANES;
   localparam int SEL_W = (NSEL > 1) ? $clog2(NSEL) : 1;
   localparam int CNT_W = ADDR_W + $clog2(NSEL) + 1;
   localparam int FULL  = DEPTH * NSEL;

   typedef enum logic {LOAD, READY} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          data_cnt_q;
   logic                      swap_pend_q;
   logic                      active_q;
   logic                      load_done_q;
   logic                      ovf_q;
   logic [CH_NUM*BIAS_W-1:0]  bias_data_q;
   logic                      bias_vld_q;

   logic [STREAM_W-1:0]       mem [2][NSEL][DEPTH];
   logic [CH_NUM*BIAS_W-1:0]  rd_word;

   logic                      full;
   logic                      wr_en;
   logic                      shadow;
   logic [SEL_W-1:0]          sel;
   logic [ADDR_W-1:0]         wr_addr;

   assign full    = (data_cnt_q == CNT_W'(FULL));
   assign sel     = SEL_W'(data_cnt_q % CNT_W'(NSEL));
   assign wr_addr = ADDR_W'(data_cnt_q / CNT_W'(NSEL));
   assign shadow  = ~active_q;
   assign wr_en   = (state_q == LOAD) && stream_bias_vld && !full;

   // Storage is never reset; only the bookkeeping around it is.
   always_ff @(posedge sclk) begin
      if (wr_en)
         mem[shadow][sel][wr_addr] <= stream_rx_data;
   end

   for (genvar g = 0; g < NSEL; g++) begin : g_rd
      assign rd_word[g*STREAM_W +: STREAM_W] =
         mem[active_q][g][bias_rd_addr];
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= LOAD;
         data_cnt_q  <= '0;
         swap_pend_q <= 1'b0;
         active_q    <= 1'b0;
         load_done_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (bank_swap)
                  swap_pend_q <= 1'b1;
               if (stream_bias_vld) begin
                  if (full)
                     ovf_q <= 1'b1;
                  if (write_finish) begin
                     data_cnt_q  <= '0;
                     load_done_q <= 1'b1;
                     state_q     <= READY;
                  end else if (!full) begin
                     data_cnt_q <= data_cnt_q + 1'b1;
                  end
               end
            end
            READY: begin
               if (stream_bias_vld)
                  ovf_q <= 1'b1;
               // A swap requested during the load fires here at once.
               if (bank_swap || swap_pend_q) begin
                  active_q    <= ~active_q;
                  swap_pend_q <= 1'b0;
                  load_done_q <= 1'b0;
                  state_q     <= LOAD;
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         bias_data_q <= '0;
         bias_vld_q  <= 1'b0;
      end else begin
         bias_vld_q <= bias_rd_en;
         if (bias_rd_en)
            bias_data_q <= rd_word;
      end
   end

   assign bias_data     = bias_data_q;
   assign bias_data_vld = bias_vld_q;
   assign load_done     = load_done_q;
   assign active_bank   = active_q;
   assign wr_overflow   = ovf_q;

endmodule

// File: tb/tb_bias_buffer_pp.sv
// Directed bench for bias_buffer_pp: load, ping-pong, early swap,
// overflow, swap/read collision and reset mid-load.
module tb_bias_buffer_pp;

   logic         sclk = 1'b0;
   logic         s_rst_n;
   logic [63:0]  stream_rx_data;
   logic         stream_bias_vld;
   logic         write_finish;
   logic         bank_swap;
   logic         bias_rd_en;
   logic [6:0]   bias_rd_addr;
   logic [255:0] bias_data;
   logic         bias_data_vld;
   logic         load_done;
   logic         active_bank;
   logic         wr_overflow;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 sclk = ~sclk;

   bias_buffer_pp dut (
      .sclk            (sclk),
      .s_rst_n         (s_rst_n),
      .stream_rx_data  (stream_rx_data),
      .stream_bias_vld (stream_bias_vld),
      .write_finish    (write_finish),
      .bank_swap       (bank_swap),
      .bias_rd_en      (bias_rd_en),
      .bias_rd_addr    (bias_rd_addr),
      .bias_data       (bias_data),
      .bias_data_vld   (bias_data_vld),
      .load_done       (load_done),
      .active_bank     (active_bank),
      .wr_overflow     (wr_overflow)
   );

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   function automatic logic [255:0] exp_seq(input logic [31:0] base);
      logic [255:0] v;
      for (int c = 0; c < 8; c++) v[c*32 +: 32] = base + 32'(c);
      return v;
   endfunction

   // Overflow beats carry {0x2000+k, 0x1000+k}; k0 is the first beat at the address.
   function automatic logic [255:0] exp_ovf(input int k0);
      logic [255:0] v;
      for (int s = 0; s < 4; s++) begin
         v[(2*s)*32 +: 32]   = 32'h1000 + 32'(k0 + s);
         v[(2*s+1)*32 +: 32] = 32'h2000 + 32'(k0 + s);
      end
      return v;
   endfunction

   task automatic cycle();
      @(posedge sclk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic fin);
      stream_rx_data  = d;
      stream_bias_vld = 1'b1;
      write_finish    = fin;
      cycle();
      stream_bias_vld = 1'b0;
      write_finish    = 1'b0;
      bank_swap       = 1'b0;
      bias_rd_en      = 1'b0;
   endtask

   task automatic load4(input logic [31:0] base);
      for (int s = 0; s < 4; s++)
         beat({base + 32'(2*s+1), base + 32'(2*s)}, s == 3);
   endtask

   task automatic swap();
      bank_swap = 1'b1;
      cycle();
      bank_swap = 1'b0;
   endtask

   task automatic rd(input logic [6:0] a);
      bias_rd_en   = 1'b1;
      bias_rd_addr = a;
      cycle();
      bias_rd_en   = 1'b0;
   endtask

   initial begin
      s_rst_n = 1'b0;
      stream_rx_data = '0;
      stream_bias_vld = 1'b0;
      write_finish = 1'b0;
      bank_swap = 1'b0;
      bias_rd_en = 1'b0;
      bias_rd_addr = '0;
      cycle();
      cycle();
      chk("rst_data", bias_data, '0);
      chk("rst_vld", 256'(bias_data_vld), 256'(0));
      chk("rst_done", 256'(load_done), 256'(0));
      chk("rst_bank", 256'(active_bank), 256'(0));
      chk("rst_ovf", 256'(wr_overflow), 256'(0));
      s_rst_n = 1'b1;
      cycle();

      // basic load into bank 1, then swap and read
      load4(32'h10);
      chk("basic_done", 256'(load_done), 256'(1));
      chk("basic_bank_pre", 256'(active_bank), 256'(0));
      swap();
      chk("basic_bank", 256'(active_bank), 256'(1));
      chk("basic_done_fall", 256'(load_done), 256'(0));
      rd(7'd0);
      chk("basic_data", bias_data, exp_seq(32'h10));
      chk("basic_vld", 256'(bias_data_vld), 256'(1));
      cycle();
      chk("idle_vld", 256'(bias_data_vld), 256'(0));
      chk("idle_hold", bias_data, exp_seq(32'h10));

      // load bank 0 while reading bank 1 every cycle
      for (int s = 0; s < 4; s++) begin
         bias_rd_en   = 1'b1;
         bias_rd_addr = 7'd0;
         beat({32'h21 + 32'(2*s), 32'h20 + 32'(2*s)}, s == 3);
         chk("pp_read", bias_data, exp_seq(32'h10));
      end
      chk("pp_done", 256'(load_done), 256'(1));

      // read on the swap edge returns the old bank
      bank_swap    = 1'b1;
      bias_rd_en   = 1'b1;
      bias_rd_addr = 7'd0;
      cycle();
      bank_swap = 1'b0;
      chk("coll_old", bias_data, exp_seq(32'h10));
      chk("coll_bank", 256'(active_bank), 256'(0));
      cycle();
      bias_rd_en = 1'b0;
      chk("coll_new", bias_data, exp_seq(32'h20));

      // early swap during the load of bank 1
      bank_swap = 1'b1;
      beat({32'h31, 32'h30}, 1'b0);
      chk("early_b1", 256'(active_bank), 256'(0));
      beat({32'h33, 32'h32}, 1'b0);
      chk("early_b2", 256'(active_bank), 256'(0));
      beat({32'h35, 32'h34}, 1'b0);
      chk("early_b3", 256'(active_bank), 256'(0));
      beat({32'h37, 32'h36}, 1'b1);
      chk("early_fin_bank", 256'(active_bank), 256'(0));
      chk("early_fin_done", 256'(load_done), 256'(1));
      cycle();
      chk("early_swap_bank", 256'(active_bank), 256'(1));
      chk("early_swap_done", 256'(load_done), 256'(0));
      rd(7'd0);
      chk("early_data", bias_data, exp_seq(32'h30));

      // overflow on bank 0
      for (int k = 1; k <= 512; k++)
         beat({32'h2000 + 32'(k), 32'h1000 + 32'(k)}, 1'b0);
      chk("ovf_full_clear", 256'(wr_overflow), 256'(0));
      beat({32'h2000 + 32'd513, 32'h1000 + 32'd513}, 1'b0);
      chk("ovf_set", 256'(wr_overflow), 256'(1));
      beat(64'h0, 1'b1);
      chk("ovf_fin_done", 256'(load_done), 256'(1));
      beat({32'hAAAA_AAAA, 32'hBBBB_BBBB}, 1'b0);
      chk("ready_drop_ovf", 256'(wr_overflow), 256'(1));
      chk("ready_drop_done", 256'(load_done), 256'(1));
      swap();
      chk("ovf_bank", 256'(active_bank), 256'(0));
      rd(7'd127);
      chk("ovf_addr127", bias_data, exp_ovf(509));
      rd(7'd0);
      chk("ovf_addr0", bias_data, exp_ovf(1));

      // reset after two beats into bank 1
      beat({32'h51, 32'h50}, 1'b0);
      beat({32'h53, 32'h52}, 1'b0);
      s_rst_n = 1'b0;
      #1;
      chk("mrst_data", bias_data, '0);
      chk("mrst_vld", 256'(bias_data_vld), 256'(0));
      chk("mrst_done", 256'(load_done), 256'(0));
      chk("mrst_bank", 256'(active_bank), 256'(0));
      chk("mrst_ovf", 256'(wr_overflow), 256'(0));
      cycle();
      s_rst_n = 1'b1;
      cycle();
      load4(32'h60);
      chk("mrst_ld_done", 256'(load_done), 256'(1));
      swap();
      chk("mrst_ld_bank", 256'(active_bank), 256'(1));
      rd(7'd0);
      chk("mrst_ld_data", bias_data, exp_seq(32'h60));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
